// File: rtl/audio_wave_pkg.sv
// rtl/audio_wave_pkg.sv - shared widths, mode enum and sine table generator
// for the audio waveform synthesiser.
package audio_wave_pkg;

  localparam int C_PH_W    = 12;
  localparam int C_SMP_W   = 12;
  localparam int C_SIN_AMP = 2047;

  typedef enum logic {
    MODE_SINE = 1'b0,
    MODE_TRI  = 1'b1
  } wave_mode_e;

  // round(C_SIN_AMP * sin(pi*k/2048)) for k in 0..1024, Q60 Taylor series
  // evaluated at elaboration time so the table needs no external data file.
  function automatic logic [10:0] sin_quarter(input logic [10:0] k);
    logic [127:0] pi_q60;
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] acc;
    pi_q60 = 128'h3243_F6A8_885A_308D;
    x      = (pi_q60 * {117'd0, k}) >> 11;
    x2     = (x * x) >> 60;
    term   = x;
    acc    = x;
    for (int n = 1; n <= 12; n++) begin
      term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
      if ((n % 2) == 1) acc = acc - term;
      else              acc = acc + term;
    end
    acc = (acc * 128'(C_SIN_AMP) + (128'd1 << 59)) >> 60;
    return 11'(acc);
  endfunction

endpackage

// File: rtl/audio_wave_synth_if.sv
// rtl/audio_wave_synth_if.sv - control and DAC pin bundle between UI logic
// and the synthesiser core.
interface audio_wave_synth_if #(
  parameter int C_PERIOD_W = 26
);
  logic                  EN_CK_i;
  logic [C_PERIOD_W-1:0] PULSE_N_i;
  logic                  WAVE_MODE_i;
  logic [7:0]            VOL_i;
  logic                  EN_WAVE_o;
  logic                  DAC_P_o;
  logic                  DAC_N_o;

  modport master (
    output EN_CK_i, PULSE_N_i, WAVE_MODE_i, VOL_i,
    input  EN_WAVE_o, DAC_P_o, DAC_N_o
  );

  modport slave (
    input  EN_CK_i, PULSE_N_i, WAVE_MODE_i, VOL_i,
    output EN_WAVE_o, DAC_P_o, DAC_N_o
  );
endinterface

// File: rtl/ds_dac_1bit.sv
// rtl/ds_dac_1bit.sv - first-order delta-sigma DAC with registered
// complementary outputs, running every clock.
module ds_dac_1bit #(
  parameter int C_DAT_W = 12
) (
  input  logic               CK_i,
  input  logic               XARST_i,
  input  logic [C_DAT_W-1:0] dat,
  output logic               dac_p,
  output logic               dac_n
);

  logic [C_DAT_W:0] acc_q;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      acc_q <= '0;
      dac_p <= 1'b0;
      dac_n <= 1'b1;
    end else begin
      acc_q <= {1'b0, acc_q[C_DAT_W-1:0]} + {1'b0, dat};
      dac_p <= acc_q[C_DAT_W];
      dac_n <= ~acc_q[C_DAT_W];
    end
  end

endmodule

// File: rtl/frac_tim_div.sv
// rtl/frac_tim_div.sv - fractional-rate divider, emits pulse_n pulses per
// C_FCK enabled clocks without long-term drift.
module frac_tim_div #(
  parameter int C_FCK      = 48_000_000,
  parameter int C_PERIOD_W = 26
) (
  input  logic                  CK_i,
  input  logic                  XARST_i,
  input  logic                  en,
  input  logic [C_PERIOD_W-1:0] pulse_n,
  output logic                  en_wave
);

  localparam logic [C_PERIOD_W:0] C_FCK_V = (C_PERIOD_W + 1)'(C_FCK);

  logic [C_PERIOD_W:0] acc_q;
  logic [C_PERIOD_W:0] sum;

  assign sum = acc_q + {1'b0, pulse_n};

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      acc_q   <= '0;
      en_wave <= 1'b0;
    end else if (en) begin
      // A step of a full period or more would overrun the residue; pin it.
      if ({1'b0, pulse_n} >= C_FCK_V) begin
        acc_q   <= '0;
        en_wave <= 1'b1;
      end else if (sum >= C_FCK_V) begin
        acc_q   <= sum - C_FCK_V;
        en_wave <= 1'b1;
      end else begin
        acc_q   <= sum;
        en_wave <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sin_lut_s12.sv
// rtl/sin_lut_s12.sv - registered signed 12-bit sine of the phase, built from
// a folded quarter-wave table.
module sin_lut_s12
  import audio_wave_pkg::*;
(
  input  logic                      CK_i,
  input  logic                      XARST_i,
  input  logic                      en,
  input  logic [C_PH_W-1:0]         phase,
  output logic signed [C_SMP_W-1:0] sin_q
);

  logic [10:0] rom [0:1024];

  for (genvar g = 0; g <= 1024; g++) begin : g_rom
    localparam logic [10:0] C_Q = sin_quarter(11'(g));
    assign rom[g] = C_Q;
  end

  logic signed [11:0]        idx;
  logic [11:0]               mag;
  logic [10:0]               q;
  logic signed [11:0]        mag_v;
  logic signed [C_SMP_W-1:0] sin_d;

  // sin is odd about idx=0 and symmetric about |idx|=1024.
  always_comb begin
    idx   = {~phase[11], phase[10:0]};
    mag   = idx[11] ? -idx : idx;
    q     = (mag > 12'd1024) ? 11'(12'd2048 - mag) : mag[10:0];
    mag_v = {1'b0, rom[q]};
    sin_d = idx[11] ? -mag_v : mag_v;
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i)  sin_q <= '0;
    else if (en)   sin_q <= sin_d;
  end

endmodule

// File: rtl/audio_wave_synth.sv
// rtl/audio_wave_synth.sv - synthesiser top: divider, phase counter, sine or
// triangle select, volume scaling and delta-sigma output.
module audio_wave_synth
  import audio_wave_pkg::*;
#(
  parameter int C_FCK      = 48_000_000,
  parameter int C_PERIOD_W = 26,
  parameter int C_DAT_W    = 12
) (
  input logic               CK_i,
  input logic               XARST_i,
  audio_wave_synth_if.slave bus
);

  logic                      en_wave;
  logic [C_PH_W-1:0]         p_q;
  logic [C_PH_W-1:0]         p_d_q;
  logic signed [C_SMP_W-1:0] sin_q;
  logic [10:0]               tri_mask;
  logic [C_SMP_W-1:0]        tri_t;
  logic signed [C_SMP_W-1:0] tri_s;
  logic signed [C_SMP_W-1:0] r_q;
  logic signed [19:0]        w_d;
  logic signed [19:0]        w_q;
  logic [C_DAT_W-1:0]        dac_d;
  wave_mode_e                mode;

  frac_tim_div #(
    .C_FCK      (C_FCK),
    .C_PERIOD_W (C_PERIOD_W)
  ) u_div (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .en      (bus.EN_CK_i),
    .pulse_n (bus.PULSE_N_i),
    .en_wave (en_wave)
  );

  assign bus.EN_WAVE_o = en_wave;

  sin_lut_s12 u_sin (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .en      (bus.EN_CK_i),
    .phase   (p_q),
    .sin_q   (sin_q)
  );

  // p_d_q lags p_q by one enabled cycle so the triangle lines up with sin_q.
  always_comb begin
    tri_mask = ((p_d_q[11:10] == 2'b01) || (p_d_q[11:10] == 2'b10)) ? '1 : '0;
    tri_t    = {~p_d_q[11], tri_mask ^ {p_d_q[9:0], 1'b0}};
    tri_s    = {~tri_t[11], tri_t[10:0]};
    mode     = wave_mode_e'(bus.WAVE_MODE_i);
    w_d      = 20'(r_q) * $signed({12'd0, bus.VOL_i});
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      p_q   <= '0;
      p_d_q <= '0;
      r_q   <= '0;
      w_q   <= '0;
    end else if (bus.EN_CK_i) begin
      if (en_wave) p_q <= p_q + 12'd1;
      p_d_q <= p_q;
      r_q   <= (mode == MODE_TRI) ? tri_s : sin_q;
      w_q   <= w_d;
    end
  end

  // Flip the sign bit and keep the top 12 bits: signed 0 lands on 0x800.
  assign dac_d = C_DAT_W'((w_q ^ 20'h80000) >> 8);

  ds_dac_1bit #(
    .C_DAT_W (C_DAT_W)
  ) u_dac (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .dat     (dac_d),
    .dac_p   (bus.DAC_P_o),
    .dac_n   (bus.DAC_N_o)
  );

endmodule

// File: tb/tb_audio_wave_synth.sv
// tb/tb_audio_wave_synth.sv - directed bench for audio_wave_synth with a
// 1000 Hz divider period.
module tb_audio_wave_synth;

  localparam int C_FCK = 1000;
  localparam int C_PW  = 26;

  logic clk   = 1'b0;
  logic xarst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  audio_wave_synth_if #(.C_PERIOD_W(C_PW)) bus ();

  audio_wave_synth #(
    .C_FCK      (C_FCK),
    .C_PERIOD_W (C_PW),
    .C_DAT_W    (12)
  ) dut (
    .CK_i    (clk),
    .XARST_i (xarst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_sin(input int p);
    case (p)
      0:       return 0;
      256:     return -783;
      512:     return -1447;
      1024:    return -2047;
      2048:    return 0;
      2560:    return 1447;
      3072:    return 2047;
      default: return 9999;
    endcase
  endfunction

  function automatic int exp_tri(input int p);
    case (p)
      0:       return 0;
      1023:    return 2046;
      1024:    return 2047;
      2047:    return 1;
      2048:    return -1;
      3072:    return -2048;
      default: return 9999;
    endcase
  endfunction

  task automatic do_reset();
    xarst           = 1'b0;
    bus.EN_CK_i     = 1'b0;
    bus.PULSE_N_i   = '0;
    repeat (2) @(negedge clk);
    xarst = 1'b1;
  endtask

  task automatic count_ones(input int n, output int ones, output int ncompl);
    ones   = 0;
    ncompl = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.DAC_P_o) ones++;
      if (bus.DAC_N_o == bus.DAC_P_o) ncompl++;
    end
  endtask

  task automatic hold_and_measure(input string tag, input int exp_ones);
    int ones;
    int ncompl;
    bus.EN_CK_i = 1'b0;
    repeat (2) @(negedge clk);
    count_ones(4096, ones, ncompl);
    chk(tag, ones, exp_ones);
    chk({tag, "_compl"}, ncompl, 0);
    bus.EN_CK_i = 1'b1;
  endtask

  task automatic sweep(input bit tri_mode, input int ncyc);
    int ph1 = -1;
    int ph2 = -1;
    int ph3 = -1;
    int cur;
    int e;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cur = int'(dut.p_q);
      if (c == 2000) chk("phase_cnt", cur, 1999);
      if (!tri_mode) begin
        e = exp_sin(ph1);
        if (e != 9999) chk($sformatf("sin_p%0d", ph1), int'(dut.sin_q), e);
        e = exp_sin(ph2);
        if (e != 9999) chk($sformatf("r_sin_p%0d", ph2), int'(dut.r_q), e);
        e = exp_sin(ph3);
        if (e != 9999) chk($sformatf("w_vol0_p%0d", ph3), int'(dut.w_q), 0);
      end else begin
        e = exp_tri(ph2);
        if (e != 9999) chk($sformatf("r_tri_p%0d", ph2), int'(dut.r_q), e);
        e = exp_tri(ph3);
        if (e != 9999) chk($sformatf("w_tri_p%0d", ph3), int'(dut.w_q), e * 255);
        if (ph3 == 1024) hold_and_measure("dac_ones_pos", 4087);
        if (ph3 == 3072) hold_and_measure("dac_ones_neg", 8);
      end
      ph3 = ph2;
      ph2 = ph1;
      ph1 = cur;
    end
  endtask

  initial begin
    int ones;
    int ncompl;
    int npulse;
    int pt [3];
    int cnt;
    int m;
    int prev;

    bus.EN_CK_i     = 1'b0;
    bus.PULSE_N_i   = '0;
    bus.WAVE_MODE_i = 1'b0;
    bus.VOL_i       = 8'd0;
    xarst           = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en_wave", int'(bus.EN_WAVE_o), 0);
    chk("rst_dac_p", int'(bus.DAC_P_o), 0);
    chk("rst_dac_n", int'(bus.DAC_N_o), 1);
    xarst = 1'b1;

    // VOL=0 leaves D at mid-scale: strict alternation, half density.
    repeat (4) @(negedge clk);
    prev = int'(bus.DAC_P_o);
    cnt  = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (int'(bus.DAC_P_o) != prev) cnt++;
      prev = int'(bus.DAC_P_o);
    end
    chk("mid_alternate", cnt, 16);
    count_ones(4096, ones, ncompl);
    chk("mid_ones", ones, 2048);
    chk("mid_compl", ncompl, 0);

    bus.PULSE_N_i = 26'd3;
    bus.EN_CK_i   = 1'b1;
    npulse = 0;
    pt     = '{0, 0, 0};
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      if (bus.EN_WAVE_o) begin
        if (npulse < 3) pt[npulse] = n;
        npulse++;
      end
    end
    chk("div_count", npulse, 3);
    chk("div_t1", pt[0], 334);
    chk("div_t2", pt[1], 667);
    chk("div_t3", pt[2], 1000);

    @(negedge clk);
    chk("div_after_t3", int'(bus.EN_WAVE_o), 0);
    bus.EN_CK_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.EN_WAVE_o) cnt++;
    end
    chk("div_hold", cnt, 0);
    bus.EN_CK_i = 1'b1;
    m = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (bus.EN_WAVE_o && m == 0) m = i;
    end
    chk("div_resume", m, 333);

    bus.PULSE_N_i = 26'd1000;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.EN_WAVE_o) cnt++;
    end
    chk("div_full", cnt, 20);
    bus.PULSE_N_i = 26'd1500;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.EN_WAVE_o) cnt++;
    end
    chk("div_over", cnt, 20);
    bus.PULSE_N_i = 26'd999;
    @(negedge clk);
    chk("div_sat_acc", int'(bus.EN_WAVE_o), 0);
    bus.PULSE_N_i = 26'd0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0 && bus.EN_WAVE_o) cnt++;
    end
    chk("div_zero", cnt, 0);

    do_reset();
    bus.WAVE_MODE_i = 1'b0;
    bus.VOL_i       = 8'd0;
    bus.PULSE_N_i   = 26'd1000;
    bus.EN_CK_i     = 1'b1;
    sweep(1'b0, 3100);

    do_reset();
    bus.WAVE_MODE_i = 1'b1;
    bus.VOL_i       = 8'd255;
    bus.PULSE_N_i   = 26'd1000;
    bus.EN_CK_i     = 1'b1;
    sweep(1'b1, 3100);

    chk("pre_rst_en_wave", int'(bus.EN_WAVE_o), 1);
    #2 xarst = 1'b0;
    #1;
    chk("async_en_wave", int'(bus.EN_WAVE_o), 0);
    chk("async_dac_p", int'(bus.DAC_P_o), 0);
    chk("async_dac_n", int'(bus.DAC_N_o), 1);
    chk("async_phase", int'(dut.p_q), 0);
    chk("async_w", int'(dut.w_q), 0);
    @(negedge clk);
    xarst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
